// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage back end: condition codes, jXX/cmovXX condition, E->M register.
// Optional CC_TRACE_EN adds a CC update counter and last-updater {icode,ifun} capture.
module execute_cc_stage #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valE,
  input  logic             e_aluOF,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             cc_block,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             cnd,
  output logic [2:0]       cc,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
`ifdef CC_TRACE_EN
  ,
  output logic [31:0]      cc_updates,
  output logic [7:0]       cc_last_icode_ifun
`endif
);

  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ  = 4'h6;

  logic       cc_update_s;
  logic       zf_s;
  logic       sf_s;
  logic       of_s;
  logic       lt_s;
  logic [3:0] dste_eff_s;

  assign zf_s = cc[2];
  assign sf_s = cc[1];
  assign of_s = cc[0];
  assign lt_s = sf_s ^ of_s;

  // CC write enable; a stalled M stage freezes the instruction so its flags must not land yet
  always_comb begin
    cc_update_s = e_valid & (e_icode == I_OPQ) & ~cc_block & ~m_stall;
  end

  // jXX/cmovXX condition from the registered flags
  always_comb begin
    cnd = 1'b0;
    case (e_ifun)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = lt_s | zf_s;
      4'h2:    cnd = lt_s;
      4'h3:    cnd = zf_s;
      4'h4:    cnd = ~zf_s;
      4'h5:    cnd = ~lt_s;
      4'h6:    cnd = ~lt_s & ~zf_s;
      default: cnd = 1'b0;
    endcase
  end

  // A cmov whose condition fails writes no register
  always_comb begin
    if ((e_icode == I_CMOV) && !cnd) begin
      dste_eff_s = RNONE;
    end else begin
      dste_eff_s = e_dstE;
    end
  end

  // Condition-code register
  always_ff @(posedge clk) begin
    if (reset) begin
      cc <= 3'b100;
    end else if (cc_update_s) begin
      cc <= {(e_valE == {WIDTH{1'b0}}), e_valE[WIDTH-1], e_aluOF};
    end else begin
      cc <= cc;
    end
  end

  // E->M pipeline register: reset, then stall, then bubble, then load
  always_ff @(posedge clk) begin
    if (reset || (!m_stall && m_bubble)) begin
      M_valid <= 1'b0;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= {WIDTH{1'b0}};
      M_valA  <= {WIDTH{1'b0}};
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (m_stall) begin
      M_valid <= M_valid;
      M_icode <= M_icode;
      M_cnd   <= M_cnd;
      M_valE  <= M_valE;
      M_valA  <= M_valA;
      M_dstE  <= M_dstE;
      M_dstM  <= M_dstM;
    end else begin
      M_valid <= e_valid;
      M_icode <= e_icode;
      M_cnd   <= cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= dste_eff_s;
      M_dstM  <= e_dstM;
    end
  end

`ifdef CC_TRACE_EN
  // Trace counter of performed CC updates and identity of the last updater
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_updates         <= 32'h0000_0000;
      cc_last_icode_ifun <= 8'h00;
    end else if (cc_update_s) begin
      cc_updates         <= cc_updates + 32'h0000_0001;
      cc_last_icode_ifun <= {e_icode, e_ifun};
    end else begin
      cc_updates         <= cc_updates;
      cc_last_icode_ifun <= cc_last_icode_ifun;
    end
  end
`endif

endmodule

// File: tb/tb_execute_cc_stage.sv
// Self-checking bench for execute_cc_stage: directed steps plus randomized cycles
// checked against a flag/pipeline reference model.
module tb_execute_cc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] e_valE;
  logic        e_aluOF;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        cc_block;
  logic        m_stall;
  logic        m_bubble;
  logic        cnd;
  logic [2:0]  cc;
  logic        M_valid;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
`ifdef CC_TRACE_EN
  logic [31:0] cc_updates;
  logic [7:0]  cc_last_icode_ifun;
`endif

  int passed = 0;
  int total  = 0;

  // reference model state
  logic        zf_m, sf_m, of_m;
  logic        mv_m;
  logic [3:0]  mi_m;
  logic        mc_m;
  logic [63:0] mve_m, mva_m;
  logic [3:0]  mde_m, mdm_m;
`ifdef CC_TRACE_EN
  logic [31:0] upd_m;
  logic [7:0]  last_m;
`endif

  execute_cc_stage #(.WIDTH(64), .RNONE(4'hF)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valE(e_valE), .e_aluOF(e_aluOF), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .cc_block(cc_block), .m_stall(m_stall), .m_bubble(m_bubble), .cnd(cnd), .cc(cc),
    .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
`ifdef CC_TRACE_EN
    , .cc_updates(cc_updates), .cc_last_icode_ifun(cc_last_icode_ifun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Jump/cmov condition in terms of signed-compare outcomes
  function automatic logic ref_cnd(input logic z, input logic s, input logic o, input logic [3:0] f);
    logic less;
    less = (s != o);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return less || z;
      4'd2:    return less;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return !less;
      4'd6:    return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_nop();
    mv_m = 1'b0; mi_m = 4'h1; mc_m = 1'b0; mve_m = 64'd0; mva_m = 64'd0;
    mde_m = 4'hF; mdm_m = 4'hF;
  endtask

  task automatic idle();
    reset = 1'b0; e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; e_valE = 64'd0;
    e_aluOF = 1'b0; e_valA = 64'd0; e_dstE = 4'hF; e_dstM = 4'hF;
    cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
  endtask

  task automatic opq(input logic [3:0] f, input logic [63:0] v, input logic ov);
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = f; e_valE = v; e_aluOF = ov;
    e_valA = 64'h1234; e_dstE = 4'h2; e_dstM = 4'hF;
  endtask

  // One clock: check cnd before the edge, advance the model, check registered state after
  task automatic step(input string tag);
    logic ec;
    ec = ref_cnd(zf_m, sf_m, of_m, e_ifun);
    chk({tag, ".cnd"}, {63'd0, cnd}, {63'd0, ec});
    @(posedge clk);
    if (reset) begin
      zf_m = 1'b1; sf_m = 1'b0; of_m = 1'b0;
      model_nop();
`ifdef CC_TRACE_EN
      upd_m = 32'd0; last_m = 8'h00;
`endif
    end else begin
      if (e_valid && e_icode == 4'h6 && !cc_block && !m_stall) begin
        zf_m = (e_valE == 64'd0); sf_m = e_valE[63]; of_m = e_aluOF;
`ifdef CC_TRACE_EN
        upd_m = upd_m + 32'd1; last_m = {e_icode, e_ifun};
`endif
      end
      if (m_stall) begin
      end else if (m_bubble) begin
        model_nop();
      end else begin
        mv_m = e_valid; mi_m = e_icode; mc_m = ec; mve_m = e_valE; mva_m = e_valA;
        mde_m = (e_icode == 4'h2 && !ec) ? 4'hF : e_dstE;
        mdm_m = e_dstM;
      end
    end
    #1;
    chk({tag, ".cc"},      {61'd0, cc},      {61'd0, zf_m, sf_m, of_m});
    chk({tag, ".M_valid"}, {63'd0, M_valid}, {63'd0, mv_m});
    chk({tag, ".M_icode"}, {60'd0, M_icode}, {60'd0, mi_m});
    chk({tag, ".M_cnd"},   {63'd0, M_cnd},   {63'd0, mc_m});
    chk({tag, ".M_valE"},  M_valE,           mve_m);
    chk({tag, ".M_valA"},  M_valA,           mva_m);
    chk({tag, ".M_dstE"},  {60'd0, M_dstE},  {60'd0, mde_m});
    chk({tag, ".M_dstM"},  {60'd0, M_dstM},  {60'd0, mdm_m});
`ifdef CC_TRACE_EN
    chk({tag, ".cc_updates"}, {32'd0, cc_updates}, {32'd0, upd_m});
    chk({tag, ".cc_last"},    {56'd0, cc_last_icode_ifun}, {56'd0, last_m});
`endif
  endtask

  initial begin
    zf_m = 1'b0; sf_m = 1'b0; of_m = 1'b0;
    model_nop();
`ifdef CC_TRACE_EN
    upd_m = 32'd0; last_m = 8'h00;
`endif
    idle();
    #2;
    // reset
    reset = 1'b1;
    @(posedge clk); #1;
    step("reset");
    chk("reset.cc_const", {61'd0, cc}, 64'd4);
    chk("reset.M_icode_const", {60'd0, M_icode}, 64'd1);
    idle(); e_ifun = 4'h3;
    step("post_reset_e");
    chk("post_reset.cnd_e", {63'd0, cnd}, 64'd1);

    // subtract to zero
    opq(4'h1, 64'd0, 1'b0); step("subq_zero");
    chk("subq_zero.cc_const", {61'd0, cc}, 64'd4);
    idle(); e_ifun = 4'h4; step("cnd_ne");
    idle(); e_ifun = 4'h1; step("cnd_le");

    // negative with overflow
    opq(4'h0, 64'h8000_0000_0000_0000, 1'b1); step("neg_of");
    chk("neg_of.cc_const", {61'd0, cc}, 64'd3);
    idle(); e_ifun = 4'h2; step("cnd_l");
    idle(); e_ifun = 4'h5; step("cnd_ge");

    // cmov with false/true condition under cc=000
    opq(4'h0, 64'd1, 1'b0); step("cc_clear");
    idle(); e_valid = 1'b1; e_icode = 4'h2; e_ifun = 4'h3; e_dstE = 4'h3; e_valA = 64'h55;
    step("cmove_false");
    chk("cmove_false.M_dstE_const", {60'd0, M_dstE}, 64'hF);
    e_ifun = 4'h0; step("rrmovq");
    chk("rrmovq.M_dstE_const", {60'd0, M_dstE}, 64'h3);

    // stall, stall+bubble, bubble, cc_block
    opq(4'h0, 64'd5, 1'b0); m_stall = 1'b1; step("stall");
    m_bubble = 1'b1; step("stall_bubble");
    m_stall = 1'b0; step("bubble");
    chk("bubble.M_icode_const", {60'd0, M_icode}, 64'd1);
    opq(4'h1, 64'd0, 1'b0); cc_block = 1'b1; step("cc_block");
    idle(); e_ifun = 4'h7; step("ifun_out_of_range");
    opq(4'h1, 64'd9, 1'b0); e_valid = 1'b0; step("invalid_load");

`ifdef CC_TRACE_EN
    reset = 1'b1; step("trace_reset");
    idle(); opq(4'h0, 64'd3, 1'b0); step("trace_u1");
    opq(4'h1, 64'd4, 1'b0); m_stall = 1'b1; step("trace_stalled");
    m_stall = 1'b0; opq(4'h2, 64'd0, 1'b0); step("trace_u2");
    chk("trace.count_const", {32'd0, cc_updates}, 64'd2);
    chk("trace.last_const", {56'd0, cc_last_icode_ifun}, 64'h62);
    idle(); @(negedge clk);
    dut.cc_updates = 32'hFFFF_FFFF; upd_m = 32'hFFFF_FFFF;
    #1;
    opq(4'h3, 64'd7, 1'b0); step("trace_wrap");
    chk("trace.wrap_const", {32'd0, cc_updates}, 64'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      reset    = ($urandom_range(0, 49) == 0);
      e_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    e_icode = 4'h6;
        2:       e_icode = 4'h2;
        default: e_icode = 4'($urandom_range(0, 15));
      endcase
      e_ifun   = 4'($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0:       e_valE = 64'd0;
        1:       e_valE = {1'b1, 63'($urandom())};
        default: e_valE = {32'($urandom()), 32'($urandom())};
      endcase
      e_aluOF  = 1'($urandom_range(0, 1));
      e_valA   = {32'($urandom()), 32'($urandom())};
      e_dstE   = 4'($urandom_range(0, 15));
      e_dstM   = 4'($urandom_range(0, 15));
      cc_block = ($urandom_range(0, 7) == 0);
      m_stall  = ($urandom_range(0, 5) == 0);
      m_bubble = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/execute_cc_stage.md
Name: execute_cc_stage

Overview:
- Execute-stage back end of the Y86-64 pipeline.
- Consumes the 64-bit ALU result and overflow flag from the adder/subtractor datapath.
- Maintains the condition-code register (ZF/SF/OF) and evaluates jXX/cmovXX conditions.
- Latches the execute results into the E->M pipeline register, with stall and bubble control, for the memory stage.

Parameters:
- WIDTH, 64, datapath width of valE/valA.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- e_valid  input  1  execute-stage instruction is real (not a bubble).
- e_icode  input  4  instruction code.
- e_ifun  input  4  function code.
- e_valE  input  WIDTH  ALU result from adder/subtractor.
- e_aluOF  input  1  signed overflow from the ALU (already gated by ALU enable).
- e_valA  input  WIDTH  operand forwarded to the memory stage.
- e_dstE  input  4  ALU destination register.
- e_dstM  input  4  memory destination register.
- cc_block  input  1  downstream exception present; inhibits CC update.
- m_stall  input  1  hold the M register.
- m_bubble  input  1  load a nop into the M register.
- cnd  output  1  combinational condition result for the current instruction.
- cc  output  3  registered {ZF,SF,OF}.
- M_valid  output  1  registered.
- M_icode  output  4  registered.
- M_cnd  output  1  registered.
- M_valE  output  WIDTH  registered.
- M_valA  output  WIDTH  registered.
- M_dstE  output  4  registered.
- M_dstM  output  4  registered.

Behaviour:
- Reset (synchronous, active-high):
  - cc = 3'b100 (ZF=1, SF=0, OF=0).
  - M_valid=0, M_icode=4'h1 (nop), M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
  - Reset mid-operation discards any pending update; reset wins over stall and bubble.
- CC update:
  - Occurs when e_valid & e_icode==4'h6 (OPq) & ~cc_block & ~m_stall.
  - New values: ZF = (e_valE==0), SF = e_valE[WIDTH-1], OF = e_aluOF.
  - Otherwise cc holds.
  - New flags are visible from the next cycle; no same-cycle bypass.
- cnd is combinational from the registered cc and e_ifun:
  - 0 always = 1
  - 1 le = (SF^OF)|ZF
  - 2 l = SF^OF
  - 3 e = ZF
  - 4 ne = ~ZF
  - 5 ge = ~(SF^OF)
  - 6 g = ~(SF^OF)&~ZF
  - ifun > 6 gives cnd = 0.
- Effective dstE: if e_icode==4'h2 (cmovXX) and cnd==0, use RNONE; otherwise e_dstE.
- M register, evaluated in priority order each edge:
  1. reset.
  2. m_stall: hold all M_* values.
  3. m_bubble: load the nop values listed under reset. CC is unaffected by m_bubble.
  4. Otherwise load e_valid, e_icode, cnd, e_valE, e_valA, effective dstE, e_dstM.
- Simultaneous m_stall and m_bubble: stall wins.
- e_valid=0 with no stall/bubble: the fields are loaded unchanged but M_valid=0. Downstream ignores invalid entries.
- Latency: exactly one cycle from execute inputs to M_* outputs.
- Arithmetic: no arithmetic beyond the zero-detect and MSB tap; overflow comes only from e_aluOF.

Optional Feature:
- Macro: CC_TRACE_EN.
- When defined:
  - Adds output port cc_updates (32 bits): a counter of performed CC updates.
  - Reset value 0; increments by 1 on each cycle the CC update condition is true; wraps from 32'hFFFFFFFF to 0.
  - Adds output port cc_last_icode_ifun (8 bits): {icode,ifun} of the last updating instruction; reset 8'h00.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset check: pulse reset -> cc=3'b100, M_icode=4'h1, M_dstE=M_dstM=4'hF, M_valid=0. With ifun=3 the next cycle, cnd=1.
- Subtract to zero: OPq subq with e_valE=0, e_aluOF=0 -> next cycle cc=3'b100. Then ifun=4 (ne) gives cnd=0 and ifun=1 (le) gives cnd=1.
- Negative with overflow: OPq, e_valE=64'h8000000000000000, e_aluOF=1 -> cc=3'b011. Then ifun=2 (l) gives cnd=0 and ifun=5 (ge) gives cnd=1.
- cmovXX with false condition: cc=3'b000, e_icode=2, e_ifun=3, e_dstE=4'h3 -> next cycle M_dstE=4'hF and M_cnd=0. Same with ifun=0 -> M_dstE=4'h3.
- Stall/bubble/cc_block:
  - Assert m_stall with a new OPq (e_valE=5) -> M_* and cc unchanged.
  - Assert m_stall and m_bubble together -> hold.
  - m_bubble alone -> nop loaded.
  - OPq with cc_block=1, e_valE=0 -> cc unchanged.
- With CC_TRACE_EN: three OPq updates, one of them during m_stall -> cc_updates=2 and cc_last_icode_ifun matches the last update. Preload the counter to 32'hFFFFFFFF and perform one more update -> cc_updates=0.
